inst_fetch_unit: RTL and testbench

- Instruction-side consumer of the program counter.
- Takes the current pc from the PC register and runs an SRAM-like request/response transaction to instruction memory.
- Presents the fetched word to decode.
- Drives `busy` back to the PC register so the PC advances only after the instruction for the current pc has been delivered and consumed.
- Handles exception redirects (`is_exp`) by discarding in-flight responses.

---
 rtl/inst_fetch_unit.sv | 104 ++++++++++
 tb/tb_inst_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one-outstanding SRAM-like fetch from pc, registered handoff to decode.
// Optional misaligned-pc fault (no memory access, inst_adel=1) under `define FETCH_ADEL_CHECK_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_stall,
    input  logic        is_exp,
    output logic        busy,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        inst_adel
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        adel_q, adel_d;
    logic        misaligned;

`ifdef FETCH_ADEL_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
    assign inst_adel  = adel_q;
`else
    assign misaligned = 1'b0;
    assign inst_adel  = 1'b0;
`endif

    assign inst_addr  = pc;
    assign inst_req   = (state_q == REQ) && !misaligned;
    assign busy       = (state_q != VALID);
    assign inst_valid = (state_q == VALID);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        adel_d    = adel_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A redirect accepted alongside addr_ok still owes us a response.
                if (is_exp)
                    state_d = (inst_req && inst_addr_ok) ? DROP : REQ;
                else if (misaligned) begin
                    state_d   = VALID;
                    inst_d    = 32'h0;
                    inst_pc_d = pc;
                    adel_d    = 1'b1;
                end else if (inst_addr_ok)
                    state_d = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (is_exp)
                        state_d = REQ;
                    else begin
                        state_d   = VALID;
                        inst_d    = inst_rdata;
                        inst_pc_d = pc;
                        adel_d    = 1'b0;
                    end
                end else if (is_exp)
                    state_d = DROP;
            end
            VALID: if (is_exp || !pc_stall) state_d = REQ;
            DROP:  if (inst_data_ok) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            inst_q    <= 32'h0;
            inst_pc_q <= RESET_PC;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            adel_q    <= adel_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: expected deliveries queued when data is returned, checked when inst_valid rises.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_stall, is_exp;
    logic        busy, inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, inst_adel;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   acc_cnt = 0;
    logic prev_valid = 1'b0;

    inst_fetch_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_stall(pc_stall), .is_exp(is_exp),
        .busy(busy), .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_adel(inst_adel)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every fresh delivery must match the oldest queued expectation.
    always @(negedge clk) begin
        if (inst_req === 1'b1 && inst_addr_ok === 1'b1) acc_cnt++;
        if (inst_valid === 1'b1 && prev_valid !== 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL delivery: unexpected inst=%h inst_pc=%h", inst, inst_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({inst, inst_pc, inst_adel} !== {e.inst, e.pc, e.adel}) begin
                    fails++;
                    $display("FAIL delivery: got inst=%h pc=%h adel=%b, want inst=%h pc=%h adel=%b",
                             inst, inst_pc, inst_adel, e.inst, e.pc, e.adel);
                end
            end
        end
        prev_valid = inst_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in REQ; ends in VALID with the expectation queued.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int aw, input int dw);
        pc = a;
        #1;
        tests++;
        if (inst_req !== 1'b1 || inst_addr !== a || busy !== 1'b1) begin
            fails++;
            $display("FAIL fetch_req: req=%b addr=%h busy=%b, want req=1 addr=%h busy=1", inst_req, inst_addr, busy, a);
        end
        for (int i = 0; i < aw; i++) begin
            inst_addr_ok = 1'b0;
            tick();
            tests++;
            if (inst_req !== 1'b1 || inst_addr !== a) begin
                fails++;
                $display("FAIL fetch_hold_req: req=%b addr=%h, want req=1 addr=%h", inst_req, inst_addr, a);
            end
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        for (int i = 0; i < dw; i++) begin
            tests++;
            if (inst_req !== 1'b0 || busy !== 1'b1 || inst_valid !== 1'b0) begin
                fails++;
                $display("FAIL fetch_wait: req=%b busy=%b valid=%b, want 0 1 0", inst_req, busy, inst_valid);
            end
            tick();
        end
        inst_data_ok = 1'b1;
        inst_rdata   = d;
        exp_q.push_back('{d, a, 1'b0});
        tick();
        inst_data_ok = 1'b0;
        tests++;
        if (busy !== 1'b0 || inst_valid !== 1'b1) begin
            fails++;
            $display("FAIL fetch_valid: busy=%b valid=%b, want busy=0 valid=1", busy, inst_valid);
        end
    endtask

    task automatic consume();
        pc_stall = 1'b0;
        tick();
        tests++;
        if (inst_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL consume: valid=%b busy=%b, want valid=0 busy=1", inst_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inst_data_ok = 1'b1;
        repeat (3) tick();
        inst_data_ok = 1'b0;
        tests++;
        if ({inst_valid, inst_req, busy, inst_adel} !== 4'b0010 || inst_pc !== 32'hbfc0_0000 || inst !== 32'h0) begin
            fails++;
            $display("FAIL reset: valid/req/busy/adel=%b%b%b%b pc=%h inst=%h, want 0010 bfc00000 0",
                     inst_valid, inst_req, busy, inst_adel, inst_pc, inst);
        end
    endtask

    task automatic test_first_fetch();
        int a0;
        reset = 1'b1;
        pc = 32'hbfc0_0000;
        tick();
        a0 = acc_cnt;
        do_fetch(32'hbfc0_0000, 32'h3c08_0001, 0, 0);
        tests++;
        if (inst !== 32'h3c08_0001 || inst_pc !== 32'hbfc0_0000 || acc_cnt - a0 != 1) begin
            fails++;
            $display("FAIL first_fetch: inst=%h pc=%h accepted=%0d, want 3c080001 bfc00000 1", inst, inst_pc, acc_cnt - a0);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'hbfc0_0004 + 32'(4 * i), $urandom, i % 3, (i + 1) % 2);
            consume();
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        do_fetch(32'hbfc0_0100, d, 0, 1);
        pc_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (inst_valid !== 1'b1 || inst !== d || inst_pc !== 32'hbfc0_0100 || busy !== 1'b0 || inst_req !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: valid=%b inst=%h pc=%h busy=%b req=%b, want 1 %h bfc00100 0 0",
                         inst_valid, inst, inst_pc, busy, inst_req, d);
            end
        end
        consume();
        pc = 32'hbfc0_0104;
        #1;
        tests++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0104) begin
            fails++;
            $display("FAIL stall_release: req=%b addr=%h, want 1 bfc00104", inst_req, inst_addr);
        end
        // Redirect while stalled in VALID wins over the stall.
        do_fetch(32'hbfc0_0104, 32'h1111_2222, 0, 0);
        pc_stall = 1'b1;
        is_exp   = 1'b1;
        tick();
        is_exp   = 1'b0;
        pc_stall = 1'b0;
        pc = 32'hbfc0_0380;
        #1;
        tests++;
        if (inst_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0380) begin
            fails++;
            $display("FAIL exp_valid: valid=%b req=%b addr=%h, want 0 1 bfc00380", inst_valid, inst_req, inst_addr);
        end
    endtask

    task automatic test_exp_wait();
        pc = 32'hbfc0_0200;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        is_exp = 1'b1;
        tick();
        is_exp = 1'b0;
        pc = 32'hbfc0_0380;
        tests++;
        if (inst_req !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL exp_wait_drop: req=%b busy=%b, want 0 1", inst_req, busy);
        end
        tick();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hdead_beef;
        tick();
        inst_data_ok = 1'b0;
        tests++;
        if (inst_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0380) begin
            fails++;
            $display("FAIL exp_wait_resume: valid=%b req=%b addr=%h, want 0 1 bfc00380", inst_valid, inst_req, inst_addr);
        end
        // Redirect coinciding with data_ok in WAIT: data discarded, straight back to REQ.
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        is_exp = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata = 32'hbad0_0001;
        tick();
        is_exp = 1'b0;
        inst_data_ok = 1'b0;
        tests++;
        if (inst_valid !== 1'b0 || inst_req !== 1'b1) begin
            fails++;
            $display("FAIL exp_wait_data: valid=%b req=%b, want 0 1", inst_valid, inst_req);
        end
        do_fetch(32'hbfc0_0380, 32'h1234_5678, 1, 0);
        consume();
    endtask

    task automatic test_exp_addr_ok();
        pc = 32'hbfc0_0300;
        inst_addr_ok = 1'b1;
        is_exp = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        is_exp = 1'b0;
        pc = 32'hbfc0_0400;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (inst_req !== 1'b0 || busy !== 1'b1 || inst_valid !== 1'b0) begin
                fails++;
                $display("FAIL exp_addr_drop: req=%b busy=%b valid=%b, want 0 1 0", inst_req, busy, inst_valid);
            end
            tick();
        end
        inst_data_ok = 1'b1;
        inst_rdata = 32'hbad0_0002;
        tick();
        inst_data_ok = 1'b0;
        tests++;
        if (inst_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0400) begin
            fails++;
            $display("FAIL exp_addr_resume: valid=%b req=%b addr=%h, want 0 1 bfc00400", inst_valid, inst_req, inst_addr);
        end
        do_fetch(32'hbfc0_0400, 32'h0bad_f00d, 0, 2);
        consume();
    endtask

    task automatic test_reset_wait();
        pc = 32'hbfc0_0500;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        reset = 1'b0;
        tick();
        tests++;
        if (inst_valid !== 1'b0 || inst_req !== 1'b0 || busy !== 1'b1 || inst_pc !== 32'hbfc0_0000) begin
            fails++;
            $display("FAIL reset_wait: valid=%b req=%b busy=%b pc=%h, want 0 0 1 bfc00000", inst_valid, inst_req, busy, inst_pc);
        end
        reset = 1'b1;
        pc = 32'hbfc0_0000;
        inst_data_ok = 1'b1;
        inst_rdata = 32'hbad0_0003;
        tick();
        inst_data_ok = 1'b0;
        tests++;
        if (inst_valid !== 1'b0 || inst_req !== 1'b1) begin
            fails++;
            $display("FAIL stray_data_ok: valid=%b req=%b, want 0 1", inst_valid, inst_req);
        end
        do_fetch(32'hbfc0_0000, 32'h2408_0005, 0, 0);
        consume();
    endtask

    task automatic test_adel();
        int a0;
        a0 = acc_cnt;
        pc = 32'hbfc0_0002;
        #1;
`ifdef FETCH_ADEL_CHECK_EN
        tests++;
        if (inst_req !== 1'b0) begin
            fails++;
            $display("FAIL adel_req: req=%b, want 0", inst_req);
        end
        exp_q.push_back('{32'h0, 32'hbfc0_0002, 1'b1});
        tick();
        tests++;
        if (inst_valid !== 1'b1 || inst_adel !== 1'b1 || acc_cnt != a0) begin
            fails++;
            $display("FAIL adel_valid: valid=%b adel=%b accepted=%0d, want 1 1 0", inst_valid, inst_adel, acc_cnt - a0);
        end
        consume();
        do_fetch(32'hbfc0_0004, 32'h0000_0021, 0, 0);
        consume();
`else
        do_fetch(32'hbfc0_0002, 32'h0000_0021, 0, 0);
        tests++;
        if (inst_adel !== 1'b0 || acc_cnt - a0 != 1) begin
            fails++;
            $display("FAIL adel_off: adel=%b accepted=%0d, want 0 1", inst_adel, acc_cnt - a0);
        end
        consume();
`endif
    endtask

    initial begin
        reset = 1'b0; pc = 32'hbfc0_0000; pc_stall = 1'b0; is_exp = 1'b0;
        inst_addr_ok = 1'b0; inst_rdata = 32'h0; inst_data_ok = 1'b0;
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_stall();
        test_exp_wait();
        test_exp_addr_ok();
        test_reset_wait();
        test_adel();
        repeat (2) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d deliveries outstanding, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
